// File: rtl/param_fifo.sv
// param_fifo: parameterised synchronous FIFO with registered read port and occupancy flags.
// Define FIFO_ERR_FLAGS_EN to enable sticky overflow/underflow; otherwise both are tied to 0.
module param_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL = (1 << ADDR_WIDTH) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
  logic wr_ok, rd_ok;
  // The extra pointer MSB distinguishes full from empty when the addresses match.
  assign count = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign almost_full = int'(count) >= AF_LEVEL;
  assign almost_empty = int'(count) <= AE_LEVEL;
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
      rd_valid <= rd_ok;
    end
  end
  always_ff @(posedge clk)
    if (wr_ok && !rst) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow <= overflow | (wr_en & full);
      underflow <= underflow | (rd_en & empty);
    end
  end
`else
  assign overflow = 1'b0;
  assign underflow = 1'b0;
`endif
endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, with depth DEPTH = 2^ADDR_WIDTH words.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, the almost_full threshold in words.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, the almost_empty threshold in words.
REQ-005 The block SHALL have port clk  input  1  sole clock, all state changes on rising edge.
REQ-006 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 The block SHALL have port wr_en  input  1  write request.
REQ-008 The block SHALL have port wr_data  input  DATA_WIDTH  write word.
REQ-009 The block SHALL have port rd_en  input  1  read request.
REQ-010 The block SHALL have port rd_data  output  DATA_WIDTH  registered read word.
REQ-011 The block SHALL have port rd_valid  output  1  high for exactly one cycle after an accepted read.
REQ-012 The block SHALL have port full  output  1  count == DEPTH.
REQ-013 The block SHALL have port empty  output  1  count == 0.
REQ-014 The block SHALL have port almost_full  output  1  count >= AF_LEVEL.
REQ-015 The block SHALL have port almost_empty  output  1  count <= AE_LEVEL.
REQ-016 The block SHALL have port count  output  ADDR_WIDTH+1  current occupancy, range 0..DEPTH.
REQ-017 The block SHALL have port overflow  output  1  sticky write-while-full flag.
REQ-018 The block SHALL have port underflow  output  1  sticky read-while-empty flag.

Function
REQ-019 Storage SHALL be DEPTH x DATA_WIDTH, addressed by write and read pointers of ADDR_WIDTH+1 bits; the extra MSB is the wrap bit.
REQ-020 A write SHALL be accepted when wr_en=1 and full=0 at the clock edge; the word is stored at wr_ptr and wr_ptr increments by 1.
REQ-021 A read SHALL be accepted when rd_en=1 and empty=0 at the clock edge; mem[rd_ptr] is loaded into rd_data, rd_ptr increments, and rd_valid=1 in the next cycle (1-cycle latency).
REQ-022 rd_data SHALL hold its last value when no read is accepted.
REQ-023 Pointers SHALL wrap modulo 2^(ADDR_WIDTH+1); the address is the low ADDR_WIDTH bits.
REQ-024 full SHALL be asserted when the pointer address bits are equal and the wrap bits differ; empty SHALL be asserted when the pointers are fully equal.
REQ-025 count SHALL be wr_ptr - rd_ptr computed modulo 2^(ADDR_WIDTH+1).
REQ-026 All status outputs SHALL be derived from registered state and SHALL be valid in the same cycle as the pointer update.
REQ-027 Simultaneous write and read, with both accepted, SHALL leave count unchanged.
REQ-028 When full, wr_en is rejected even if a read is accepted in the same cycle; the read proceeds.
REQ-029 When empty, rd_en is rejected even if a write is accepted in the same cycle; the write proceeds.
REQ-030 A rejected request SHALL change no pointer, memory word, or rd_data.

Reset
REQ-031 When rst=1 at a clock edge: wr_ptr=0, rd_ptr=0, rd_data=0, rd_valid=0, overflow=0, underflow=0.
REQ-032 After reset: empty=1, full=0, count=0, almost_empty=1, almost_full=0 (for AF_LEVEL>0).
REQ-033 Reset SHALL take priority over wr_en/rd_en in the same cycle; memory contents are not cleared.
REQ-034 Asserting reset mid-operation SHALL discard all stored words.

Configuration
REQ-035 With FIFO_ERR_FLAGS_EN defined: overflow SHALL set on wr_en=1 while full=1, underflow SHALL set on rd_en=1 while empty=1, both cleared only by rst.
REQ-036 Without FIFO_ERR_FLAGS_EN: overflow and underflow SHALL be tied to 0; all other behaviour is identical.

Verification
REQ-037 Reset, then write 0x0001..0x0010 (16 words, defaults) -> full=1 after the 16th write, count=16, almost_full=1 from count=14.
REQ-038 Full FIFO, wr_en=1 with 0xDEAD -> write dropped; with FIFO_ERR_FLAGS_EN overflow=1 and stays 1 until rst; later reads return 0x0001..0x0010 in order.
REQ-039 Read 16 words -> rd_data=0x0001..0x0010 each one cycle after rd_en, rd_valid pulses each time, empty=1 at end; an extra rd_en gives no rd_valid and sets underflow (macro on).
REQ-040 Count at 8, simultaneous wr_en/rd_en for 20 cycles -> count stays 8, pointers wrap past 31 to 0, data order preserved.
REQ-041 Full FIFO, simultaneous wr_en/rd_en -> read accepted, write rejected, count=15.
REQ-042 rst asserted with 5 words stored and wr_en=1 -> next cycle count=0, empty=1, rd_valid=0, rd_data=0.
